// File: rtl/ncl_barrel_driver.sv
// ncl_barrel_driver: launches DATA then NULL wavefronts into the NCL barrel shifter and returns the result.
// Optional golden-model result check (check_fail/fail_seen ports) enabled by defining RESULT_CHECK_EN.
module ncl_barrel_driver #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [1:0] cmd_shift,
    input  logic       cmd_sra,
    input  logic       cmd_rotate,
    input  logic       cmd_value,
    output logic [1:0] a0_dr,
    output logic [1:0] a1_dr,
    output logic [1:0] a2_dr,
    output logic [1:0] a3_dr,
    output logic [1:0] sra_dr,
    output logic [1:0] rotate_dr,
    output logic [1:0] shift1_dr,
    output logic [1:0] shift0_dr,
    output logic [1:0] value_dr,
    input  logic [1:0] out0_dr,
    input  logic [1:0] out1_dr,
    input  logic [1:0] out2_dr,
    input  logic [1:0] out3_dr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
`ifdef RESULT_CHECK_EN
    output logic       check_fail,
    output logic       fail_seen,
`endif
    output logic       busy
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, NULL_PH, RESP} state_t;
    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]      w_in, w_s, r_prev;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_timer;
    logic [8:0][1:0] r_drv;
    logic [8:0]      w_bits;
    logic [3:0]      r_data;
    logic            r_err;
    logic            w_s_illegal, w_p_data, w_complete_data, w_complete_null;
    logic            w_timeout, w_done, w_accept;

    assign w_in   = {out3_dr, out2_dr, out1_dr, out0_dr};
    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_bits = {cmd_value, cmd_shift[0], cmd_shift[1], cmd_rotate, cmd_sra, cmd_a};

    always_comb begin
        w_s_illegal = 1'b0;
        w_p_data    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_s_illegal = w_s_illegal | (&w_s[2*i +: 2]);
            w_p_data    = w_p_data & (^r_prev[2*i +: 2]);
        end
    end

    // r_cnt counts consecutive identical samples of the word held in r_prev
    assign w_complete_data = w_p_data && r_cnt == CW'(SETTLE_CYCLES);
    assign w_complete_null = r_prev == 8'h00 && r_cnt == CW'(SETTLE_CYCLES);
    assign w_timeout       = r_timer == TW'(TIMEOUT_CYCLES - 1);
    assign w_done          = r_state == DATA ? w_complete_data : w_complete_null;
    assign cmd_ready       = r_state == IDLE && w_complete_null;
    assign w_accept        = cmd_valid && cmd_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = DATA;
            DATA:    if (w_complete_data || w_timeout) w_next = NULL_PH;
            NULL_PH: if (w_complete_null || w_timeout) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_prev  <= w_s;
            r_cnt   <= w_s != r_prev ? CW'(1) : (r_cnt == CW'(SETTLE_CYCLES) ? r_cnt : r_cnt + 1'b1);
            r_timer <= w_next != r_state ? '0 : r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drv  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) begin
                for (int i = 0; i < 9; i++) r_drv[i] <= {w_bits[i], ~w_bits[i]};
                r_err <= 1'b0;
            end else if (r_state == DATA || r_state == NULL_PH) begin
                r_err <= r_err | w_s_illegal | (w_timeout && !w_done);
            end
            if (r_state == DATA && w_next == NULL_PH) begin
                r_drv  <= '0;
                r_data <= w_complete_data ? {r_prev[7], r_prev[5], r_prev[3], r_prev[1]} : 4'h0;
            end
        end
    end

    assign {value_dr, shift0_dr, shift1_dr, rotate_dr, sra_dr, a3_dr, a2_dr, a1_dr, a0_dr} = r_drv;
    assign rsp_valid = r_state == RESP;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;
    assign busy      = r_state != IDLE;

`ifdef RESULT_CHECK_EN
    logic [3:0] r_exp;
    logic [7:0] w_ext, w_sh;
    logic       r_fail_seen;

    assign w_ext = {cmd_rotate ? cmd_a : {4{cmd_sra ? cmd_a[3] : cmd_value}}, cmd_a};
    assign w_sh  = w_ext >> cmd_shift;
    assign check_fail = rsp_valid && !r_err && r_data != r_exp;
    assign fail_seen  = r_fail_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp       <= '0;
            r_fail_seen <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) r_exp <= w_sh[3:0];
            r_fail_seen <= r_fail_seen | check_fail;
        end
    end
`endif
endmodule

// File: tb/tb_ncl_barrel_driver.sv
// tb_ncl_barrel_driver: directed bench with a behavioural 3-cycle NCL shifter model.
module tb_ncl_barrel_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [1:0] cmd_shift = '0;
    logic       cmd_sra = 1'b0, cmd_rotate = 1'b0, cmd_value = 1'b0;
    logic [1:0] a0_dr, a1_dr, a2_dr, a3_dr, sra_dr, rotate_dr, shift1_dr, shift0_dr, value_dr;
    logic [1:0] out0_dr, out1_dr, out2_dr, out3_dr;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [3:0] rsp_data;
`ifdef RESULT_CHECK_EN
    logic       check_fail, fail_seen, last_cf;
`endif

    always #5 clk = ~clk;

    ncl_barrel_driver dut (
`ifdef RESULT_CHECK_EN
        .check_fail(check_fail),
        .fail_seen(fail_seen),
`endif
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_shift(cmd_shift),
        .cmd_sra(cmd_sra), .cmd_rotate(cmd_rotate), .cmd_value(cmd_value),
        .a0_dr(a0_dr), .a1_dr(a1_dr), .a2_dr(a2_dr), .a3_dr(a3_dr), .sra_dr(sra_dr),
        .rotate_dr(rotate_dr), .shift1_dr(shift1_dr), .shift0_dr(shift0_dr), .value_dr(value_dr),
        .out0_dr(out0_dr), .out1_dr(out1_dr), .out2_dr(out2_dr), .out3_dr(out3_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    int n_run = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural shifter: evaluates once every rail pair is DATA, returns NULL once all are NULL
    logic [17:0] w_drv;
    logic        m_hang = 1'b0, m_corrupt = 1'b0;
    logic [7:0]  p0 = '0, p1 = '0, p2 = '0, m_word, m_ext, m_sh;
    logic [3:0]  m_a, m_res;
    logic        m_all_data, m_all_null;
    int          cyc = 0, m_force_until = 0;

    assign w_drv = {value_dr, shift0_dr, shift1_dr, rotate_dr, sra_dr, a3_dr, a2_dr, a1_dr, a0_dr};

    always_comb begin
        m_all_data = 1'b1;
        for (int i = 0; i < 9; i++) m_all_data = m_all_data & (^w_drv[2*i +: 2]);
        m_all_null = w_drv == 18'h0;
        m_a   = {a3_dr[1], a2_dr[1], a1_dr[1], a0_dr[1]};
        m_ext = {rotate_dr[1] ? m_a : {4{sra_dr[1] ? m_a[3] : value_dr[1]}}, m_a};
        m_sh  = m_ext >> {shift1_dr[1], shift0_dr[1]};
        m_res = m_sh[3:0];
        if (m_corrupt && m_res == 4'hf) m_res[2] = 1'b0;
        m_word = '0;
        for (int i = 0; i < 4; i++) m_word[2*i +: 2] = {m_res[i], ~m_res[i]};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_all_data) p0 <= m_hang ? 8'h00 : m_word;
        else if (m_all_null) p0 <= 8'h00;
        p1 <= p0;
        p2 <= p1;
    end

    assign out0_dr = p2[1:0];
    assign out1_dr = p2[3:2];
    assign out2_dr = cyc < m_force_until ? 2'b11 : p2[5:4];
    assign out3_dr = p2[7:6];

    // Drive-sequence monitor: DATA straight to a different DATA is a protocol violation
    logic [17:0] last_drv = '0;
    int          dd_viol = 0, null_cnt = 0;
    always @(posedge clk) begin
        if (w_drv != 0 && last_drv != 0 && w_drv != last_drv) dd_viol <= dd_viol + 1;
        if (last_drv != 0 && w_drv == 0) null_cnt <= null_cnt + 1;
        last_drv <= w_drv;
    end

    task automatic do_cmd(input logic [3:0] a, input logic [1:0] sh, input logic sra, input logic rot,
                          input logic val, input logic force_ill,
                          output logic [3:0] d, output logic e, output int lat);
        int k;
        k = 0;
        while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) check("cmd_ready_timeout", 0, 1);
        cmd_a = a; cmd_shift = sh; cmd_sra = sra; cmd_rotate = rot; cmd_value = val;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (force_ill) m_force_until = cyc + 5;
        lat = 0;
        while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
        if (lat >= 300) check("rsp_timeout", 0, 1);
        d = rsp_data;
        e = rsp_err;
`ifdef RESULT_CHECK_EN
        last_cf = check_fail;
`endif
        check("drv_null_at_rsp", 32'(w_drv), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 0);
        check("busy_drop", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] d;
        logic       e;
        int         lat, n0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drives", 32'(w_drv), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        rst_n = 1'b1;

        do_cmd(4'b1011, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, d, e, lat);
        check("t1_data", 32'(d), 32'h5);
        check("t1_err", 32'(e), 0);

        n0 = null_cnt;
        do_cmd(4'b1001, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, d, e, lat);
        check("rot_data", 32'(d), 32'h6);
        check("rot_err", 32'(e), 0);
        do_cmd(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, d, e, lat);
        check("sra_data", 32'(d), 32'hf);
        check("sra_err", 32'(e), 0);
        check("no_data_after_data", 32'(dd_viol), 0);
        check("null_phases", 32'(null_cnt - n0), 2);

        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_rsp_ready_valid", 32'(rsp_valid), 0);
        check("idle_rsp_ready_busy", 32'(busy), 0);
        rsp_ready = 1'b0;

        m_hang = 1'b1;
        do_cmd(4'b0011, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, d, e, lat);
        m_hang = 1'b0;
        check("tmo_data", 32'(d), 0);
        check("tmo_err", 32'(e), 1);
        check("tmo_latency_ge_64", 32'(lat >= 64), 1);

        do_cmd(4'b0110, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, d, e, lat);
        check("ill_data", 32'(d), 32'hb);
        check("ill_err", 32'(e), 1);

        do_cmd(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, d, e, lat);
        check("err_cleared_data", 32'(d), 32'h1);
        check("err_cleared_err", 32'(e), 0);

        while (!cmd_ready) @(negedge clk);
        cmd_a = 4'b1111; cmd_shift = 2'd0; cmd_sra = 1'b0; cmd_rotate = 1'b0; cmd_value = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_drives_data", 32'(w_drv != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_drives", 32'(w_drv), 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(4'b0101, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, d, e, lat);
        check("post_rst_data", 32'(d), 32'h2);
        check("post_rst_err", 32'(e), 0);

`ifdef RESULT_CHECK_EN
        check("fail_seen_clean", 32'(fail_seen), 0);
        m_corrupt = 1'b1;
        do_cmd(4'b1111, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, d, e, lat);
        m_corrupt = 1'b0;
        check("corrupt_data", 32'(d), 32'hb);
        check("check_fail", 32'(last_cf), 1);
        check("fail_seen", 32'(fail_seen), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ncl_barrel_driver.md
Name: ncl_barrel_driver

Overview:
- Clocked bridge that launches single-rail commands into the dual-rail NCL barrel shifter.
- Drives a DATA wavefront, waits for completion on the shifter's four dual-rail outputs, and captures the result.
- Then drives a NULL wavefront and waits for full return-to-NULL before returning the result on a valid/ready port.
- Sits between the synchronous test/control fabric and the asynchronous shifter.

Parameters:
- SYNC_STAGES, 2, flop stages on every incoming rail before detection (min 2).
- SETTLE_CYCLES, 2, consecutive identical sampled cycles required to declare DATA-complete or NULL-complete (min 1).
- TIMEOUT_CYCLES, 64, max cycles spent in a wavefront phase before abort (min 4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high
- cmd_a  in  4  operand word, bit i is word position Ai
- cmd_shift  in  2  shift amount, {shift1,shift0}
- cmd_sra  in  1  arithmetic fill select
- cmd_rotate  in  1  rotate select
- cmd_value  in  1  fill bit used when sra=0, rotate=0
- a0_dr, a1_dr, a2_dr, a3_dr, sra_dr, rotate_dr, shift1_dr, shift0_dr, value_dr  out  2 each  dual-rail drive; [1]=true rail, [0]=false rail
- out0_dr, out1_dr, out2_dr, out3_dr  in  2 each  dual-rail shifter results, asynchronous
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when both rsp_valid and rsp_ready are high
- rsp_data  out  4  result, bit i from out i
- rsp_err  out  1  abort or illegal code seen for this command
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE; all dual-rail outputs 2'b00 (NULL).
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - Synchronizers, settle counters and timeout counter cleared.
- Sampled signals: each incoming rail passes through SYNC_STAGES flops.
  - Word is DATA when every out has exactly one rail high.
  - Word is NULL when all rails are 0.
  - Word is ILLEGAL when any out is 2'b11.
  - complete_data / complete_null assert after SETTLE_CYCLES consecutive identical DATA (or all-NULL) samples.
- cmd_ready = (state==IDLE) && complete_null. Before reset-release traffic, the shifter must be seen at NULL.
- FSM:
  - IDLE: on accept, register all dual-rail drives from the command (bit b -> {b,~b}), clear err, clear timer -> DATA.
  - DATA: hold drives.
    - On complete_data: capture rsp_data from true rails -> NULL_PH.
    - On timer==TIMEOUT_CYCLES-1: set err, rsp_data=0 -> NULL_PH.
  - NULL_PH: all drives 2'b00, timer restarts on entry.
    - On complete_null -> RESP.
    - On timeout: set err -> RESP.
  - RESP: rsp_valid=1, holds rsp_data/rsp_err stable; on rsp_ready -> IDLE (rsp_valid low next cycle).
- ILLEGAL sampled in DATA or NULL_PH sets err for the current command; the phase continues.
- Drives change only on state transitions. A DATA drive never follows a DATA drive without a NULL phase between.
- Minimum latency, accept to rsp_valid: 2 + 2*(SYNC_STAGES+SETTLE_CYCLES) + shifter delay in cycles.
- Reset mid-operation: drives return to NULL asynchronously and any pending response is discarded.
- rsp_ready held high while in IDLE has no effect.

Optional Feature:
- RESULT_CHECK_EN, when defined:
  - Adds a golden model computing the expected result at accept.
  - Model: cmd_a shifted right by cmd_shift. Vacated MSBs are filled with the rotated-out bits if rotate=1, else cmd_a[3] if sra=1, else cmd_value.
  - Adds output port check_fail (1 bit, reset 0), valid with rsp_valid: 1 when captured rsp_data != expected and err=0.
  - Adds sticky output fail_seen, cleared only by reset.
- When undefined: no model, no extra ports.
- Purpose: detecting tampered shifter paths.

Test Plan:
- a=4'b1011, shift=1, sra=0, rotate=0, value=0, behavioural shifter with 3-cycle delay -> rsp_data=4'b0101, rsp_err=0, drives NULL before rsp_valid.
- a=4'b1001, shift=2, rotate=1 -> rsp_data=4'b0110. Then a=4'b1000, shift=3, sra=1 -> 4'b1111. Both back-to-back, with one NULL phase observed between.
- Shifter model never completes DATA -> after TIMEOUT_CYCLES, NULL driven, rsp_err=1, rsp_data=0.
- Force out2_dr=2'b11 for 5 cycles during DATA -> rsp_err=1, FSM still returns to IDLE after NULL.
- rst_n low in DATA phase -> all drives 2'b00 same cycle, rsp_valid=0; next command completes normally.
- RESULT_CHECK_EN with model corrupting out2 when all internal words are 1 -> check_fail=1 and fail_seen=1 for a=4'b1111, shift=0.
